// File: rtl/count_seq_pkg.sv
// Shared types for the push-button counter sequencer.
// The mode encoding doubles as the status-LED value on mode_o.
package count_seq_pkg;

    typedef enum logic [1:0] {
        STEP  = 2'd0,
        AUTO  = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } mode_t;

endpackage

// File: rtl/press_classifier.sv
// Turns the debounced key level into one-cycle short/long press events.
// A key already held when reset releases stays ignored until it has been released.
module press_classifier #(
    parameter int unsigned LONG_PRESS = 32'd50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic short_evt_o,
    output logic long_evt_o
);

    localparam int unsigned TW = $clog2(LONG_PRESS + 32'd1);
    localparam logic [TW-1:0] LONG_C = TW'(LONG_PRESS);
    localparam logic [TW-1:0] LAST_C = TW'(LONG_PRESS - 32'd1);

    logic          key_q_r;
    logic          armed_r;
    logic [TW-1:0] timer_r;

    logic rise_s;
    logic fall_s;
    logic live_s;
    logic timer_inc_s;

    // Edge detection and event decode; the rising-edge cycle already counts as held.
    always_comb begin
        rise_s      = ~key_q_r & key_i;
        fall_s      = key_q_r & ~key_i;
        live_s      = armed_r | rise_s;
        timer_inc_s = live_s & key_i & (timer_r < LONG_C);
        long_evt_o  = timer_inc_s & (timer_r == LAST_C);
        short_evt_o = armed_r & fall_s & (timer_r < LONG_C);
    end

    // Key history, arming flag and the saturating hold timer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q_r <= 1'b1;
            armed_r <= 1'b0;
            timer_r <= {TW{1'b0}};
        end else begin
            key_q_r <= key_i;
            if (rise_s) begin
                armed_r <= 1'b1;
            end
            if (fall_s) begin
                timer_r <= {TW{1'b0}};
            end else if (timer_inc_s) begin
                timer_r <= timer_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Mode controller for the 8-bit counter: STEP / AUTO / PAUSE / CLEAR driven by one button.
// All outputs are registered, so every action shows up one clock after its event.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned LONG_PRESS  = 32'd50_000_000,
    parameter int unsigned AUTO_PERIOD = 32'd25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_i,
    output logic       next_o,
    output logic       clr_o,
    output logic [1:0] mode_o
);

    localparam int unsigned TKW = $clog2(AUTO_PERIOD);
    localparam logic [TKW-1:0] TICK_LAST = TKW'(AUTO_PERIOD - 32'd1);

    mode_t          state_r;
    mode_t          state_s;
    logic [TKW-1:0] tick_r;
    logic [TKW-1:0] tick_s;
    logic           next_r;
    logic           next_s;
    logic           clr_r;
    logic           clr_s;
    logic           short_s;
    logic           long_s;
    logic           tick_done_s;

    press_classifier #(
        .LONG_PRESS (LONG_PRESS)
    ) u_press (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .key_i       (key_i),
        .short_evt_o (short_s),
        .long_evt_o  (long_s)
    );

    // Next-state and pulse decode; a press event always beats an AUTO tick.
    always_comb begin
        state_s     = state_r;
        next_s      = 1'b0;
        tick_done_s = (tick_r == TICK_LAST);
        case (state_r)
            STEP: begin
                if (long_s) begin
                    state_s = AUTO;
                end else if (short_s) begin
                    next_s = 1'b1;
                end else begin
                    state_s = STEP;
                end
            end
            AUTO: begin
                if (long_s) begin
                    state_s = CLEAR;
                end else if (short_s) begin
                    state_s = PAUSE;
                end else if (tick_done_s) begin
                    next_s = 1'b1;
                end else begin
                    state_s = AUTO;
                end
            end
            PAUSE: begin
                if (long_s) begin
                    state_s = CLEAR;
                end else if (short_s) begin
                    state_s = AUTO;
                end else begin
                    state_s = PAUSE;
                end
            end
            CLEAR: begin
                state_s = STEP;
            end
            default: begin
                state_s = STEP;
            end
        endcase
        clr_s = (state_s == CLEAR);
    end

    // Tick counter: runs only while staying in AUTO, frozen in PAUSE, restarts on every AUTO entry.
    always_comb begin
        if ((state_r == AUTO) && (state_s == AUTO)) begin
            if (tick_done_s) begin
                tick_s = {TKW{1'b0}};
            end else begin
                tick_s = tick_r + 1'b1;
            end
        end else if (state_s == PAUSE) begin
            tick_s = tick_r;
        end else begin
            tick_s = {TKW{1'b0}};
        end
    end

    // State, tick and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= STEP;
            tick_r  <= {TKW{1'b0}};
            next_r  <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            next_r  <= next_s;
            clr_r   <= clr_s;
        end
    end

    assign mode_o = state_r;
    assign next_o = next_r;
    assign clr_o  = clr_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Scenario bench for count_sequencer with LONG_PRESS=8, AUTO_PERIOD=4.
// Rows are {rst, key, next, clr, mode}: inputs for one clock and the outputs expected after it.
module tb_count_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       key_i;
    logic       next_o;
    logic       clr_o;
    logic [1:0] mode_o;

    int         tests = 0;
    int         fails = 0;
    logic [5:0] stim[$];
    logic [3:0] sb[$];

    count_sequencer #(
        .LONG_PRESS  (32'd8),
        .AUTO_PERIOD (32'd4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .key_i  (key_i),
        .next_o (next_o),
        .clr_o  (clr_o),
        .mode_o (mode_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic row(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v);
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        stim.delete();
        row(6'b1_0_0_0_00, 3);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL reset[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_step();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_0_0_0_00, 1);
        row(6'b0_1_0_0_00, 3);
        row(6'b0_0_1_0_00, 1);
        row(6'b0_0_0_0_00, 2);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL step[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_long_auto();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_1_0_0_00, 7);
        row(6'b0_1_0_0_01, 4);
        row(6'b0_1_1_0_01, 1);
        row(6'b0_0_0_0_01, 3);
        row(6'b0_0_1_0_01, 1);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL long_auto[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_1_0_0_01, 3);
        row(6'b0_0_0_0_10, 7);
        row(6'b0_1_0_0_10, 2);
        row(6'b0_0_0_0_01, 4);
        row(6'b0_0_1_0_01, 1);
        row(6'b0_1_0_0_01, 2);
        row(6'b0_0_0_0_10, 1);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL pause[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_clear();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_1_0_0_10, 7);
        row(6'b0_1_0_1_11, 1);
        row(6'b0_0_0_0_00, 3);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL clear[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_held_reset();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_1_0_0_00, 2);
        row(6'b1_1_0_0_00, 3);
        row(6'b0_1_0_0_00, 5);
        row(6'b0_0_0_0_00, 3);
        row(6'b0_1_0_0_00, 2);
        row(6'b0_0_1_0_00, 1);
        row(6'b0_0_0_0_00, 1);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL held_reset[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_reset_mid_auto();
        logic [3:0] exp;
        stim.delete();
        row(6'b0_1_0_0_00, 7);
        row(6'b0_1_0_0_01, 3);
        row(6'b1_0_0_0_00, 1);
        row(6'b0_0_0_0_00, 5);
        foreach (stim[i]) begin
            rst_i = stim[i][5];
            key_i = stim[i][4];
            sb.push_back(stim[i][3:0]);
            @(negedge clk_i);
            exp = sb.pop_front();
            tests++;
            if ({next_o, clr_o, mode_o} !== exp) begin
                fails++;
                $display("FAIL reset_mid_auto[%0d]: next/clr/mode got %b/%b/%0d, expected %b/%b/%0d",
                         i, next_o, clr_o, mode_o, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        key_i = 1'b0;
        test_reset();
        test_step();
        test_long_auto();
        test_pause();
        test_clear();
        test_held_reset();
        test_reset_mid_auto();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
